// File: rtl/sim_console_mon.sv
// rtl/sim_console_mon.sv - console byte snooper: per-channel line FIFOs, whole-line arbiter, pass/fail/timeout status
// Lines are forwarded atomically: a channel is only granted once a full line (or a full FIFO) is waiting.
module sim_console_mon #(
  parameter  int          NCH         = 2,
  parameter  int          DEPTH       = 64,
  parameter  int unsigned TIMEOUT_CYC = 32'd1000000,
  localparam int          CW          = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             sysclk_i,
  input  logic             rstn_i,
  input  logic [NCH-1:0]   wr_i,
  input  logic [8*NCH-1:0] wdata_i,
  output logic             out_valid_o,
  output logic [7:0]       out_data_o,
  output logic [CW-1:0]    out_chan_o,
  input  logic             out_ready_i,
  output logic [7:0]       sim_flag_o,
  output logic             pass_o,
  output logic             fail_o,
  output logic             timeout_o,
  output logic             done_o,
  output logic [15:0]      drop_cnt_o
);

  localparam int          AW     = $clog2(DEPTH);
  localparam int          LASTI  = DEPTH - 1;
  localparam logic [AW:0] FULL   = DEPTH[AW:0];
  localparam logic [AW:0] LAST   = LASTI[AW:0];
  localparam logic [31:0] PASS_W = 32'h50415353;
  localparam logic [31:0] FAIL_W = 32'h4641494C;

  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [7:0]      mem [NCH][DEPTH];
  logic [AW-1:0]   wptr_q [NCH];
  logic [AW-1:0]   rptr_q [NCH];
  logic [AW:0]     cnt_q [NCH];
  logic [AW:0]     lc_q [NCH];
  logic [23:0]     sh_q [NCH];
  logic [7:0]      wbyte [NCH];
  logic [7:0]      head [NCH];
  logic [NCH-1:0]  push, pop, elig;
  logic [CW-1:0]   rr_q, rr_d, grant_q, grant_d, pick;
  logic            any_elig;
  logic [AW:0]     acc_q, acc_d;
  logic            vld_q, vld_d;
  logic [7:0]      data_q, data_d;
  logic [3:0]      ndrop;
  logic            pass_hit, fail_hit;
  logic [16:0]     drop_sum;
  logic [15:0]     drop_q;
  logic            pass_q, fail_q, to_q, done;
  logic [31:0]     idle_q;

  // A write is refused whenever the FIFO was full at the start of the cycle, even if a pop frees a slot.
  always_comb begin
    ndrop    = '0;
    pass_hit = 1'b0;
    fail_hit = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      wbyte[c] = wdata_i[8*c +: 8];
      head[c]  = mem[c][rptr_q[c]];
      push[c]  = wr_i[c] && (cnt_q[c] != FULL);
      elig[c]  = (lc_q[c] != '0) || (cnt_q[c] == FULL);
      if (wr_i[c] && !push[c]) ndrop = ndrop + 4'd1;
      if (wr_i[c] && ({sh_q[c], wbyte[c]} == PASS_W)) pass_hit = 1'b1;
      if (wr_i[c] && ({sh_q[c], wbyte[c]} == FAIL_W)) fail_hit = 1'b1;
    end
  end

  // Scan downwards so the lowest offset after the last grant wins.
  always_comb begin
    pick     = rr_q;
    any_elig = 1'b0;
    for (int i = NCH; i >= 1; i--) begin
      if (elig[(int'(rr_q) + i) % NCH]) begin
        pick     = CW'((int'(rr_q) + i) % NCH);
        any_elig = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    acc_d   = acc_q;
    vld_d   = vld_q;
    data_d  = data_q;
    pop     = '0;
    case (state_q)
      IDLE: begin
        if (any_elig) begin
          state_d   = DRAIN;
          rr_d      = pick;
          grant_d   = pick;
          acc_d     = '0;
          pop[pick] = 1'b1;
          vld_d     = 1'b1;
          data_d    = head[pick];
        end
      end
      DRAIN: begin
        if (vld_q && out_ready_i) begin
          acc_d = acc_q + (AW+1)'(1);
          if (data_q == 8'h0A || acc_q == LAST) begin
            vld_d   = 1'b0;
            state_d = IDLE;
          end else if (cnt_q[grant_q] != '0) begin
            pop[grant_q] = 1'b1;
            data_d       = head[grant_q];
          end else begin
            vld_d = 1'b0;
          end
        end else if (!vld_q && cnt_q[grant_q] != '0) begin
          pop[grant_q] = 1'b1;
          vld_d        = 1'b1;
          data_d       = head[grant_q];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysclk_i) begin
    for (int c = 0; c < NCH; c++) begin
      if (push[c]) mem[c][wptr_q[c]] <= wbyte[c];
    end
  end

  always_ff @(posedge sysclk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int c = 0; c < NCH; c++) begin
        wptr_q[c] <= '0;
        rptr_q[c] <= '0;
        cnt_q[c]  <= '0;
        lc_q[c]   <= '0;
        sh_q[c]   <= '0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (push[c]) wptr_q[c] <= wptr_q[c] + AW'(1);
        if (pop[c])  rptr_q[c] <= rptr_q[c] + AW'(1);
        if (wr_i[c]) sh_q[c]   <= {sh_q[c][15:0], wbyte[c]};
        cnt_q[c] <= cnt_q[c] + {{AW{1'b0}}, push[c]} - {{AW{1'b0}}, pop[c]};
        lc_q[c]  <= lc_q[c] + {{AW{1'b0}}, (push[c] && wbyte[c] == 8'h0A)}
                            - {{AW{1'b0}}, (pop[c] && head[c] == 8'h0A)};
      end
    end
  end

  always_ff @(posedge sysclk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      rr_q    <= CW'(NCH - 1);
      grant_q <= '0;
      acc_q   <= '0;
      vld_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      acc_q   <= acc_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
    end
  end

  assign done     = pass_q | fail_q | to_q;
  assign drop_sum = {1'b0, drop_q} + {13'd0, ndrop};

  always_ff @(posedge sysclk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      drop_q <= '0;
      pass_q <= 1'b0;
      fail_q <= 1'b0;
      to_q   <= 1'b0;
      idle_q <= '0;
    end else begin
      drop_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      if (pass_hit) pass_q <= 1'b1;
      if (fail_hit) fail_q <= 1'b1;
      if (|wr_i) begin
        idle_q <= '0;
      end else if (!done) begin
        idle_q <= idle_q + 32'd1;
        if (TIMEOUT_CYC != 0 && (idle_q + 32'd1) == TIMEOUT_CYC) to_q <= 1'b1;
      end
    end
  end

  assign out_valid_o = vld_q;
  assign out_data_o  = data_q;
  assign out_chan_o  = grant_q;
  assign sim_flag_o  = wr_i[0] ? wdata_i[7:0] : 8'h00;
  assign pass_o      = pass_q;
  assign fail_o      = fail_q;
  assign timeout_o   = to_q;
  assign done_o      = done;
  assign drop_cnt_o  = drop_q;

endmodule

// File: tb/tb_sim_console_mon.sv
// tb/tb_sim_console_mon.sv - table-driven bench for sim_console_mon (NCH=2, DEPTH=4, TIMEOUT_CYC=10)
module tb_sim_console_mon;

  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  wr;
  logic [15:0] wd;
  logic        rdy;
  logic        vld;
  logic [7:0]  dat;
  logic        chn;
  logic [7:0]  flag;
  logic        pass, fail, tmo, done;
  logic [15:0] drop;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  sim_console_mon #(.NCH(2), .DEPTH(4), .TIMEOUT_CYC(10)) dut (
    .sysclk_i    (clk),
    .rstn_i      (rstn),
    .wr_i        (wr),
    .wdata_i     (wd),
    .out_valid_o (vld),
    .out_data_o  (dat),
    .out_chan_o  (chn),
    .out_ready_i (rdy),
    .sim_flag_o  (flag),
    .pass_o      (pass),
    .fail_o      (fail),
    .timeout_o   (tmo),
    .done_o      (done),
    .drop_cnt_o  (drop)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  wr;
    logic [15:0] wd;
    logic        rdy;
    logic        vld;
    logic [7:0]  dat;
    logic        chn;
    logic [15:0] drp;
  } vec_t;

  vec_t tbl[$];

  function automatic void add_row(input logic r, input logic [1:0] w, input logic [15:0] d,
                                  input logic rd, input logic v, input logic [7:0] dt,
                                  input logic c, input logic [15:0] dp);
    vec_t x;
    x.rst = r; x.wr = w; x.wd = d; x.rdy = rd; x.vld = v; x.dat = dt; x.chn = c; x.drp = dp;
    tbl.push_back(x);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0; wr = '0; wd = '0; rdy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic apply(input vec_t v, input int n);
    wr = v.wr; wd = v.wd; rdy = v.rdy;
    @(posedge clk);
    #1;
    chk($sformatf("row%0d_valid", n), 32'(vld), 32'(v.vld));
    if (v.vld) begin
      chk($sformatf("row%0d_data", n), 32'(dat), 32'(v.dat));
      chk($sformatf("row%0d_chan", n), 32'(chn), 32'(v.chn));
    end
    chk($sformatf("row%0d_drop", n), 32'(drop), 32'(v.drp));
    chk($sformatf("row%0d_simflag", n), 32'(flag), 32'(v.wr[0] ? v.wd[7:0] : 8'h00));
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] pb [6];
    logic       seen;

    do_reset();
    chk("rst_valid", 32'(vld), 0);
    chk("rst_drop", 32'(drop), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_fail", 32'(fail), 0);
    chk("rst_timeout", 32'(tmo), 0);
    chk("rst_done", 32'(done), 0);

    // "AB\n" on ch0, always ready
    add_row(1, 2'b01, 16'h0041, 1, 0, 8'h00, 0, 0);
    add_row(0, 2'b01, 16'h0042, 1, 0, 8'h00, 0, 0);
    add_row(0, 2'b01, 16'h000A, 1, 0, 8'h00, 0, 0);
    add_row(0, 2'b00, 16'h0000, 1, 1, 8'h41, 0, 0);
    add_row(0, 2'b00, 16'h0000, 1, 1, 8'h42, 0, 0);
    add_row(0, 2'b00, 16'h0000, 1, 1, 8'h0A, 0, 0);
    add_row(0, 2'b00, 16'h0000, 1, 0, 8'h00, 0, 0);
    add_row(0, 2'b00, 16'h0000, 1, 0, 8'h00, 0, 0);
    // "X\n" on ch0 and "Y\n" on ch1 together: ch0 first, bubble, then ch1
    add_row(1, 2'b11, 16'h5958, 1, 0, 8'h00, 0, 0);
    add_row(0, 2'b11, 16'h0A0A, 1, 0, 8'h00, 0, 0);
    add_row(0, 2'b00, 16'h0000, 1, 1, 8'h58, 0, 0);
    add_row(0, 2'b00, 16'h0000, 1, 1, 8'h0A, 0, 0);
    add_row(0, 2'b00, 16'h0000, 1, 0, 8'h00, 0, 0);
    add_row(0, 2'b00, 16'h0000, 1, 1, 8'h59, 1, 0);
    add_row(0, 2'b00, 16'h0000, 1, 1, 8'h0A, 1, 0);
    add_row(0, 2'b00, 16'h0000, 1, 0, 8'h00, 0, 0);
    // back-pressure: ready low 5 cycles while 8'h32 is presented
    add_row(1, 2'b01, 16'h0031, 0, 0, 8'h00, 0, 0);
    add_row(0, 2'b01, 16'h0032, 0, 0, 8'h00, 0, 0);
    add_row(0, 2'b01, 16'h000A, 0, 0, 8'h00, 0, 0);
    add_row(0, 2'b00, 16'h0000, 0, 1, 8'h31, 0, 0);
    add_row(0, 2'b00, 16'h0000, 1, 1, 8'h32, 0, 0);
    for (int i = 0; i < 5; i++) add_row(0, 2'b00, 16'h0000, 0, 1, 8'h32, 0, 0);
    add_row(0, 2'b00, 16'h0000, 1, 1, 8'h0A, 0, 0);
    add_row(0, 2'b00, 16'h0000, 1, 0, 8'h00, 0, 0);
    // ch0 line stalled; ch1 writes 6 bytes into a 4-deep FIFO -> 2 drops, then 4-byte drain
    add_row(1, 2'b11, 16'h610A, 0, 0, 8'h00, 0, 0);
    add_row(0, 2'b10, 16'h6200, 0, 1, 8'h0A, 0, 0);
    add_row(0, 2'b10, 16'h6300, 0, 1, 8'h0A, 0, 0);
    add_row(0, 2'b10, 16'h6400, 0, 1, 8'h0A, 0, 0);
    add_row(0, 2'b10, 16'h6500, 0, 1, 8'h0A, 0, 1);
    add_row(0, 2'b10, 16'h6600, 0, 1, 8'h0A, 0, 2);
    add_row(0, 2'b00, 16'h0000, 1, 0, 8'h00, 0, 2);
    add_row(0, 2'b00, 16'h0000, 1, 1, 8'h61, 1, 2);
    add_row(0, 2'b00, 16'h0000, 1, 1, 8'h62, 1, 2);
    add_row(0, 2'b00, 16'h0000, 1, 1, 8'h63, 1, 2);
    add_row(0, 2'b00, 16'h0000, 1, 1, 8'h64, 1, 2);
    add_row(0, 2'b00, 16'h0000, 1, 0, 8'h00, 0, 2);
    add_row(0, 2'b00, 16'h0000, 1, 0, 8'h00, 0, 2);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      apply(tbl[i], i);
    end

    // "xxPASS" on ch1, then a long idle stretch must not raise timeout
    do_reset();
    rdy = 1'b1;
    pb = '{8'h78, 8'h78, 8'h50, 8'h41, 8'h53, 8'h53};
    for (int i = 0; i < 6; i++) begin
      wr = 2'b10; wd = {pb[i], 8'h00};
      @(posedge clk);
      #1;
      if (i == 4) chk("pass_early", 32'(pass), 0);
      @(negedge clk);
    end
    chk("pass_set", 32'(pass), 1);
    chk("pass_done", 32'(done), 1);
    chk("pass_no_fail", 32'(fail), 0);
    wr = '0; wd = '0;
    repeat (15) @(posedge clk);
    #1;
    chk("pass_no_timeout", 32'(tmo), 0);
    chk("pass_sticky", 32'(pass), 1);
    @(negedge clk);

    // FAIL on ch0 and PASS on ch1 in the same cycles
    do_reset();
    pb[0] = 8'h46; pb[1] = 8'h41; pb[2] = 8'h49; pb[3] = 8'h4C;
    pb[4] = 8'h50; pb[5] = 8'h53;
    for (int i = 0; i < 4; i++) begin
      wr = 2'b11;
      wd = {(i == 0) ? pb[4] : (i == 1) ? 8'h41 : pb[5], pb[i]};
      @(posedge clk);
      #1;
      if (i == 2) begin
        chk("both_early_pass", 32'(pass), 0);
        chk("both_early_fail", 32'(fail), 0);
      end
      @(negedge clk);
    end
    chk("both_pass", 32'(pass), 1);
    chk("both_fail", 32'(fail), 1);
    wr = '0; wd = '0;

    // idle timeout from reset
    do_reset();
    repeat (9) @(posedge clk);
    #1;
    chk("timeout_at_9", 32'(tmo), 0);
    @(posedge clk);
    #1;
    chk("timeout_at_10", 32'(tmo), 1);
    chk("timeout_done", 32'(done), 1);
    @(negedge clk);

    // reset in the middle of a drain
    do_reset();
    pb[0] = 8'h41; pb[1] = 8'h42; pb[2] = 8'h0A;
    for (int i = 0; i < 3; i++) begin
      wr = 2'b01; wd = {8'h00, pb[i]};
      @(posedge clk);
      @(negedge clk);
    end
    wr = '0; wd = '0;
    @(posedge clk);
    #1;
    chk("drain_valid_before_rst", 32'(vld), 1);
    #2;
    rstn = 1'b0;
    #1;
    chk("rst_async_valid", 32'(vld), 0);
    @(negedge clk);
    rstn = 1'b1;
    rdy = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (vld) seen = 1'b1;
    end
    chk("rst_line_discarded", 32'(seen), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sim_console_mon.md
SIM_CONSOLE_MON -- requirements
Module: sim_console_mon

Interface
- REQ-001: Parameter NCH, default 2: number of byte-write channels snooped; legal range 1..8.
- REQ-002: Parameter DEPTH, default 64: per-channel line FIFO depth in bytes; must be a power of 2, minimum 4.
- REQ-003: Parameter TIMEOUT_CYC, default 1000000: idle-cycle limit (32-bit); 0 disables timeout.
- REQ-004: sysclk_i  in  1  sole clock; all state updates on its rising edge.
- REQ-005: rstn_i  in  1  reset, asynchronous assert, active-low.
- REQ-006: wr_i  in  NCH  per-channel byte write strobe, one byte per cycle per channel.
- REQ-007: wdata_i  in  8*NCH  channel c byte at bits [8c+7:8c].
- REQ-008: out_valid_o  out  1  merged output byte valid.
- REQ-009: out_data_o  out  8  merged output byte.
- REQ-010: out_chan_o  out  max(1,clog2(NCH))  source channel of out_data_o.
- REQ-011: out_ready_i  in  1  consumer accepts the byte when high with out_valid_o.
- REQ-012: sim_flag_o  out  8  combinational: wdata_i[7:0] when wr_i[0], else 8'h00.
- REQ-013: pass_o, fail_o, timeout_o  out  1 each  sticky status flags.
- REQ-014: done_o  out  1  pass_o | fail_o | timeout_o.
- REQ-015: drop_cnt_o  out  16  total dropped bytes, all channels, saturating at 16'hFFFF.

Function
- REQ-016: Each channel has a FIFO (DEPTH bytes) and a line counter; write at edge E pushes wdata unless FIFO count==DEPTH at start of that cycle, regardless of any concurrent pop.
- REQ-017: Dropped write increments drop_cnt_o by 1 (saturating); two or more channels dropping in one cycle add their count.
- REQ-018: Line counter +1 on push of 8'h0A, -1 on pop of 8'h0A; both in one cycle leave it unchanged.
- REQ-019: Channel is eligible when line counter > 0 or FIFO count == DEPTH.
- REQ-020: Arbiter states IDLE and DRAIN; IDLE with any eligible channel grants at next edge, round-robin starting from last-granted+1 (channel 0 first after reset), loads first byte to output register, enters DRAIN.
- REQ-021: A byte terminating a line at edge E0 on an idle, empty arbiter gives out_valid_o high after E0+1 (2-edge latency).
- REQ-022: In DRAIN, granted channel holds the output; one byte per cycle while out_ready_i high, back-to-back, no bytes of other channels interleaved.
- REQ-023: out_valid_o, out_data_o, out_chan_o stable while out_valid_o && !out_ready_i.
- REQ-024: DRAIN ends when the accepted byte is 8'h0A or DEPTH bytes of the grant are accepted; next edge returns to IDLE (one bubble cycle minimum between lines).
- REQ-025: Per-channel 32-bit shift register of every written byte (including dropped); on completing "PASS" (50 41 53 53) pass_o sets the next cycle; "FAIL" (46 41 49 4C) sets fail_o; simultaneous matches on different channels set both.
- REQ-026: Idle counter clears on any wr_i bit; else increments; reaching TIMEOUT_CYC sets timeout_o; counter freezes once done_o is high; TIMEOUT_CYC==0 never sets timeout_o.
- REQ-027: Pass/fail/timeout flags never clear except by reset.

Reset
- REQ-028: rstn_i low asynchronously clears FIFOs, line counters, shift registers, idle counter, drop_cnt_o, all flags, out_valid_o; arbiter to IDLE, round-robin pointer to channel NCH-1.
- REQ-029: Reset mid-DRAIN discards the partial line; no byte appears on the output after release until new writes terminate a line.

Verification
- REQ-030: NCH=2; ch0 writes "AB\n" cycles 0-2, ready=1 -> out 41,42,0A chan 0, first valid after edge 3 (2 edges after 0A).
- REQ-031: ch0 "X\n" and ch1 "Y\n" written in the same cycles -> output 58,0A chan0 then bubble then 59,0A chan1; never interleaved.
- REQ-032: ready held low 5 cycles mid-line -> output byte unchanged for 5 cycles, no loss.
- REQ-033: DEPTH=4; ch1 writes 6 bytes no newline, ready=0 -> drop_cnt_o=2; release ready -> 4 bytes drained chan 1, arbiter IDLE.
- REQ-034: ch1 writes "xxPASS" -> pass_o=1 cycle after final 53, done_o=1; then TIMEOUT_CYC=10 with no writes -> timeout_o stays 0.
- REQ-035: TIMEOUT_CYC=10, no writes after reset -> timeout_o=1 after 10th idle cycle; rstn_i low mid-drain -> out_valid_o=0 immediately.
